seq_scan_ctrl: RTL
==================

# seq_scan_ctrl

Stream-scanning controller around a bit-serial sequence matcher. It accepts a runtime-configured pattern of 1..MAX_LEN bits, then takes bytes over a valid/ready stream. Each byte is serialized MSB-first into the matcher, one bit per cycle, and matches are counted. It extends the fixed-pattern Mealy detectors in the FSM library into a reusable, configurable scanning engine for packet-level use.

## Interface
- MAX_LEN, 8: maximum pattern length in bits.
- CNT_W, 16: match counter width.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller can accept configuration (IDLE only)
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit expected on the wire
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
- cfg_err  out  1  one-cycle pulse when an illegal cfg_len is offered
- s_valid  in  1  input byte valid
- s_ready  out  1  controller can take a byte (ARMED only)
- s_data  in  8  input byte, serialized MSB first
- s_last  in  1  marks the final byte of the stream
- match_pulse  out  1  registered one-cycle pulse per detected match
- match_count  out  CNT_W  saturating match count for the current stream
- busy  out  1  high in ARMED/SHIFT/DONE
- done  out  1  one-cycle pulse at end of stream

## Operation
- FSM states: IDLE, ARMED, SHIFT, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid with 1<=cfg_len<=MAX_LEN: latch pattern/len; clear history, fill counter and match_count; go to ARMED.
  - On cfg_valid with an illegal length: pulse cfg_err next cycle and stay in IDLE.
- ARMED:
  - s_ready=1.
  - On s_valid: latch s_data and s_last, set bit index=7, go to SHIFT.
- SHIFT:
  - Each cycle: history <= {history[MAX_LEN-2:0], byte[idx]}; fill counter increments, saturating at MAX_LEN.
  - Match when fill (including the new bit) >= len and the new history[len-1:0] == pattern[len-1:0].
  - After idx=0: go to DONE if last, else go to ARMED.
- DONE: done=1 for one cycle, then IDLE. match_count holds until the next accepted configuration.
- History persists across byte boundaries within a stream, so patterns spanning two bytes are detected.
- match_count increments once per match and saturates at all-ones.
- Reset values: cfg_ready=1 after reset release; s_ready, cfg_err, match_pulse, busy, done = 0; match_count=0; FSM=IDLE.
- Reset mid-stream aborts immediately. No done pulse and no partial count are retained.
- Inputs are ignored outside their states: s_valid in IDLE/SHIFT/DONE, cfg_valid outside IDLE.

## Timing
- Byte handshake at cycle T (s_valid & s_ready): bit 7 is consumed at T+1, bit 0 at T+8.
- match_pulse and the match_count update for a bit consumed at cycle C appear at C+1.
- Next s_ready at T+9 if not last. Peak throughput is 1 byte per 9 cycles.
- Last byte: DONE at T+9, done pulse during T+9, cfg_ready=1 at T+10.
- The match_pulse for bit 0 of the last byte coincides with the done cycle.
- Config handshake at cycle K: ARMED (s_ready=1) from K+1.

## Configuration
- SEQ_SCAN_OVERLAP_EN defined: overlapping matches are counted; history and fill are kept after a match.
- Not defined: non-overlapping mode. The fill counter resets to 0 on a match, so the next match needs len fresh bits.

## Structure
- Package seq_scan_pkg holds:
  - the state enum (IDLE/ARMED/SHIFT/DONE);
  - default MAX_LEN and CNT_W;
  - the LEN_W function.
- Sub-module seq_match_core contains the history shift register, fill counter, length-masked compare and overlap handling.
- The seq_match_core interface: bit_valid, bit_in, clear, pattern, len, match.
- seq_scan_ctrl holds the FSM, handshakes, byte serializer and saturating counter.

## Test plan
- Pattern 3'b101, len 3, byte 0xA5 with last → 2 match_pulses, match_count=2, done at T+9, in both modes.
- Pattern 3'b101, byte 0xA8 with last → count 2 with SEQ_SCAN_OVERLAP_EN, count 1 without.
- Pattern 2'b11, bytes 0x01 then 0x80 with last → exactly 1 match, on bit 7 of the second byte (cross-byte).
- cfg_len=0, then cfg_len=9 with MAX_LEN=8 → cfg_err pulses each time; FSM stays in IDLE; s_ready stays 0.
- CNT_W=2, pattern 1'b1, len 1, byte 0xFF → 8 match_pulses; match_count saturates at 3.
- s_valid held high throughout a two-byte stream → second byte is consumed only at T+9. Then rst asserted at the 4th SHIFT cycle → all outputs at reset values next cycle, no done pulse.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the seq_scan stream-scanning controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 16;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_scan_if.sv
// Configuration, byte stream and status bundle of seq_scan_ctrl.
interface seq_scan_if import seq_scan_pkg::*; #(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int LEN_W   = len_width(MAX_LEN)
) ();

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_err;
  logic               s_valid;
  logic               s_ready;
  logic [7:0]         s_data;
  logic               s_last;
  logic               match_pulse;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, s_valid, s_data, s_last,
    input  cfg_ready, cfg_err, s_ready, match_pulse, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, s_valid, s_data, s_last,
    output cfg_ready, cfg_err, s_ready, match_pulse, match_count, busy, done
  );

endinterface

// File: rtl/seq_match_core.sv
// Bit-serial matcher: history shift register, fill counter and length-masked compare.
// SEQ_SCAN_OVERLAP_EN defined counts overlapping matches; otherwise a match restarts the fill.
module seq_match_core import seq_scan_pkg::*; #(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               clear,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic [MAX_LEN-1:0] history, hist_nxt, mask;
  logic [LEN_W-1:0]   fill, fill_nxt;

  // Match is judged on the history as it will look once the incoming bit is shifted in.
  always_comb begin
    hist_nxt = {history[MAX_LEN-2:0], bit_in};
    fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match = bit_valid && (fill_nxt >= len) && (((hist_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      history <= '0;
      fill    <= '0;
    end else if (bit_valid) begin
      history <= hist_nxt;
      if (match && !OVERLAP) begin
        fill <= '0;
      end else begin
        fill <= fill_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Stream-scanning controller: config/byte handshakes, MSB-first serializer and saturating match counter.
// Overlap behaviour of the matcher is selected by SEQ_SCAN_OVERLAP_EN.
module seq_scan_ctrl import seq_scan_pkg::*; #(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  seq_scan_if.slave  bus
);

  localparam int LEN_W = len_width(MAX_LEN);

  state_t             state, state_nxt;
  logic [7:0]         byte_q;
  logic               last_q;
  logic [2:0]         idx_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   count_q;
  logic               pulse_q;
  logic               err_q;
  logic               cfg_ok, cfg_take, byte_take, bit_valid, bit_in, core_match;

  assign cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  assign cfg_take  = (state == IDLE) && bus.cfg_valid && cfg_ok;
  assign byte_take = (state == ARMED) && bus.s_valid;
  assign bit_valid = (state == SHIFT);
  assign bit_in    = byte_q[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.cfg_ready = 1'b0;
    bus.s_ready   = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        bus.busy      = 1'b0;
        if (cfg_take) state_nxt = ARMED;
      end
      ARMED: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (idx_q == 3'd0) state_nxt = last_q ? DONE : ARMED;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: config latch, byte serializer, registered match pulse and saturating count.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q   <= (state == IDLE) && bus.cfg_valid && !cfg_ok;
      pulse_q <= core_match;
      if (cfg_take) begin
        pat_q   <= bus.cfg_pattern;
        len_q   <= bus.cfg_len;
        count_q <= '0;
      end
      if (byte_take) begin
        byte_q <= bus.s_data;
        last_q <= bus.s_last;
        idx_q  <= 3'd7;
      end else if (bit_valid) begin
        idx_q <= idx_q - 3'd1;
      end
      if (core_match && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.cfg_err     = err_q;
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = count_q;

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (cfg_take),
    .pattern   (pat_q),
    .len       (len_q),
    .match     (core_match)
  );

endmodule
